// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizes for the shift-and-add multiplier
//
// Purpose : FSM state encoding and the ALU operand width used by the
//           multiplier, its interface and its testbench.
// Ports   : none (package).
package mult_pkg;

    localparam int MULT_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - operand/product handshake bundle of the multiplier
//
// Purpose : groups the operand-side and product-side valid/ready handshakes.
// Signals : i_valid/o_ready/i_a/i_b  operand handshake (into the multiplier)
//           o_valid/i_ready/o_product product handshake (out of the multiplier)
//           o_busy                  multiplier is iterating
// Modports: master - the surrounding datapath; slave - the multiplier.
interface shift_add_multiplier_if #(
    parameter int N = mult_pkg::MULT_N
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_product;
    logic         o_busy;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_product, o_busy
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_product, o_busy
    );
endinterface

// File: rtl/shift_left_logical.sv
// rtl/shift_left_logical.sv - combinational logical left shifter
//
// Purpose : data_o = data_i << shamt_i, zero fill from the right.
// Ports   : data_i  [N-1:0]         value to shift
//           shamt_i [$clog2(N)-1:0] shift amount
//           data_o  [N-1:0]         shifted value
module shift_left_logical #(
    parameter int N = 32
) (
    input  logic [N-1:0]         data_i,
    input  logic [$clog2(N)-1:0] shamt_i,
    output logic [N-1:0]         data_o
);

    assign data_o = data_i << shamt_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative shift-and-add multiplier, low N bits of a*b
//
// Purpose : accepts a/b in IDLE, walks one multiplier bit per clock in BUSY
//           (adding a << count when b[count] is set), presents the product
//           in DONE until the consumer takes it.
// Ports   : clk  system clock, rising edge
//           rst  synchronous active-high reset
//           bus  shift_add_multiplier_if.slave (operand and product handshakes)
// Options : SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN - finish as soon as no set bits
//           of b remain above the current step.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_multiplier_if.slave bus
);

    localparam int CW = $clog2(N);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  product_q, product_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  shifted;
    logic [N-1:0]  addend;
    logic [N-1:0]  acc_sum;
    logic          last_step;

    shift_left_logical #(.N(N)) u_sll (
        .data_i  (a_q),
        .shamt_i (count_q),
        .data_o  (shifted)
    );

    // Carry out of the top bit is dropped: only the low word is kept, which
    // is the same for signed and unsigned operands.
    assign addend  = b_q[count_q] ? shifted : '0;
    assign acc_sum = acc_q + addend;

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    // No set bits above the current position means nothing more to add.
    assign last_step = ((b_q >> count_q) >> 1) == '0;
`else
    assign last_step = (count_q == CW'(N - 1));
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_sum;
                count_d = count_q + 1'b1;
                if (last_step) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_busy    = (state_q == BUSY);
    assign bus.o_valid   = (state_q == DONE);
    assign bus.o_product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;
    import mult_pkg::*;

    localparam int NOPS = 1000;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];

    shift_add_multiplier_if #(.N(MULT_N)) bus();

    shift_add_multiplier #(.N(MULT_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hi = i + 1;
        return (hi < 1) ? 1 : hi;
`else
        return 32;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] prod, output int lat,
                          output bit busy_seen, output bit to);
        int w;
        w = 0; to = 0; lat = 0; prod = '0; busy_seen = 0;
        while (!bus.o_ready && w < 200) begin step(); w++; end
        if (!bus.o_ready) begin to = 1; return; end
        bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        busy_seen = bus.o_busy;
        while (!bus.o_valid && lat < 200) begin step(); lat++; end
        if (!bus.o_valid) to = 1;
        prod = bus.o_product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_product !== 32'h0) begin errors++; $display("FAIL reset_o_product got=%h exp=0", bus.o_product); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] p; int lat; bit bs, to;
        bus.i_ready = 1'b1;
        run_op(32'd6, 32'd7, p, lat, bs, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (p !== 32'd42) begin errors++; $display("FAIL basic_product got=%0d exp=42", p); end
        checks++; if (lat != exp_lat(32'd7)) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(32'd7)); end
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bs); end
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got=%b exp=0", bus.o_ready); end
        step();
        checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_back_to_idle got=%b%b exp=10", bus.o_ready, bus.o_valid); end
    endtask

    task automatic test_corners();
        logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'd3};
        logic [31:0] tb [4] = '{32'hFFFF_FFFF, 32'd2,         32'd0,         32'd5};
        logic [31:0] te [4] = '{32'h0000_0001, 32'h0,         32'h0,         32'd15};
        logic [31:0] p; int lat; bit bs, to;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], p, lat, bs, to);
            checks++; if (to !== 1'b0 || p !== te[i]) begin errors++; $display("FAIL corner%0d_product got=%h exp=%h timeout=%b", i, p, te[i], to); end
            checks++; if (lat != exp_lat(tb[i])) begin errors++; $display("FAIL corner%0d_latency got=%0d exp=%0d", i, lat, exp_lat(tb[i])); end
            step();
        end
    endtask

    task automatic test_hold();
        int lat;
        bus.i_ready = 1'b0;
        while (!bus.o_ready && lat < 200) begin step(); lat++; end
        bus.i_a = 32'd6; bus.i_b = 32'd7; bus.i_valid = 1'b1;
        step();
        lat = 0;
        while (!bus.o_valid && lat < 200) begin
            bus.i_valid = 1'($urandom % 2);
            bus.i_a = $urandom; bus.i_b = $urandom;
            step(); lat++;
        end
        checks++; if (bus.o_valid !== 1'b1 || bus.o_product !== 32'd42) begin errors++; $display("FAIL hold_first got=%0d valid=%b exp=42", bus.o_product, bus.o_valid); end
        checks++; if (lat != exp_lat(32'd7)) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", lat, exp_lat(32'd7)); end
        for (int c = 0; c < 10; c++) begin
            bus.i_valid = 1'($urandom % 2);
            bus.i_a = $urandom; bus.i_b = $urandom;
            step();
            checks++; if (bus.o_valid !== 1'b1 || bus.o_product !== 32'd42) begin errors++; $display("FAIL hold_cycle%0d got=%0d valid=%b exp=42", c, bus.o_product, bus.o_valid); end
        end
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        step();
        checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b%b exp=10", bus.o_ready, bus.o_valid); end
        step();
        checks++; if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin errors++; $display("FAIL hold_no_phantom busy=%b ready=%b exp=01", bus.o_busy, bus.o_ready); end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] p; int lat; bit bs, to;
        bus.i_ready = 1'b1;
        bus.i_a = 32'd9; bus.i_b = 32'hFFFF_FFFF; bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        repeat (10) step();
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", bus.o_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL midrst_o_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_state valid=%b busy=%b exp=00", bus.o_valid, bus.o_busy); end
        checks++; if (bus.o_product !== 32'h0) begin errors++; $display("FAIL midrst_o_product got=%h exp=0", bus.o_product); end
        run_op(32'd3, 32'd4, p, lat, bs, to);
        checks++; if (to !== 1'b0 || p !== 32'd12) begin errors++; $display("FAIL midrst_after got=%0d exp=12 timeout=%b", p, to); end
        step();
    endtask

    task automatic test_random();
        exp_q.delete();
        fork
            begin
                int sent, guard, gap;
                bit acc;
                logic [31:0] a, b, e;
                sent = 0; guard = 0;
                while (sent < NOPS && guard < 90000) begin
                    gap = $urandom_range(0, 3);
                    bus.i_valid = 1'b0;
                    repeat (gap) begin step(); guard++; end
                    a = $urandom;
                    b = ($urandom % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                    bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
                    acc = 1'b0;
                    while (!acc && guard < 90000) begin
                        acc = bus.o_ready;
                        step(); guard++;
                    end
                    if (acc) begin
                        e = a * b;
                        exp_q.push_back(e);
                        sent++;
                    end
                end
                bus.i_valid = 1'b0;
            end
            begin
                int got, cyc;
                logic [31:0] e;
                got = 0; cyc = 0;
                while (got < NOPS && cyc < 95000) begin
                    bus.i_ready = 1'(($urandom % 3) != 0);
                    if (bus.o_valid && bus.i_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected product=%h exp=none", bus.o_product);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.o_product !== e) begin errors++; $display("FAIL rand_product%0d got=%h exp=%h", got, bus.o_product, e); end
                        end
                        got++;
                    end
                    step(); cyc++;
                end
                checks++; if (got != NOPS) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got, NOPS); end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_hold();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
